// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the digital-clock mode/alarm controller.
package clock_ctrl_pkg;

  localparam int unsigned TIME_W   = 6;
  localparam int unsigned MAX_HOUR = 23;
  localparam int unsigned MAX_MIN  = 59;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_AH = 3'd3,
    SET_AM = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    SND_NONE  = 2'd0,
    SND_CHIME = 2'd1,
    SND_ALARM = 2'd2
  } snd_e;

  typedef struct packed {
    logic [TIME_W-1:0] hour;
    logic [TIME_W-1:0] minute;
  } hm_t;

  // Increment with wrap to zero past the given maximum.
  function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] max_v);
    return (v >= max_v) ? '0 : v + TIME_W'(1);
  endfunction

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      RUN:     return SET_H;
      SET_H:   return SET_M;
      SET_M:   return SET_AH;
      SET_AH:  return SET_AM;
      default: return RUN;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-count debouncer; one press pulse per accepted press.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 2000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Count consecutive cycles that disagree with the accepted level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode sequencing, time/alarm setting, alarm ring with snooze and hourly chime
// arbitration for the digital clock.
module clock_mode_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 2000000,
  parameter int unsigned BLINK_CYCLES  = 25000000,
  parameter int unsigned RING_SECONDS  = 60,
  parameter int unsigned SNOOZE_MIN    = 5,
  parameter int unsigned CHIME_SECONDS = 2,
  parameter int unsigned ALARM_RST_H   = 7,
  parameter int unsigned ALARM_RST_M   = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              btn_mode_i,
  input  logic              btn_adj_i,
  input  logic              btn_stop_i,
  input  logic              alarm_en_i,
  input  logic [TIME_W-1:0] hour_i,
  input  logic [TIME_W-1:0] minute_i,
  input  logic [TIME_W-1:0] second_i,
  output logic              inc_hour_o,
  output logic              inc_min_o,
  output logic [2:0]        mode_o,
  output logic              show_alarm_o,
  output logic [2:0]        blink_mask_o,
  output logic [TIME_W-1:0] alarm_hour_o,
  output logic [TIME_W-1:0] alarm_minute_o,
  output logic              ringing_o,
  output logic [1:0]        snd_sel_o
);

  localparam int unsigned RING_W  = $clog2(RING_SECONDS + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_CYCLES + 1);
  localparam int unsigned SUM_W   = TIME_W + 1;

  logic mode_p, adj_p, stop_p;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_mode_i), .press_o(mode_p));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_adj (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_adj_i), .press_o(adj_p));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_stop_i), .press_o(stop_p));

  mode_e              mode_q, mode_d;
  hm_t                alarm_q, alarm_d;
  hm_t                snooze_q, snooze_d;
  logic               snooze_pend_q, snooze_pend_d;
  logic               ringing_q, ringing_d;
  logic [RING_W-1:0]  ring_cnt_q, ring_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic [TIME_W-1:0]  second_q;
  logic               inc_hour_q, inc_hour_d;
  logic               inc_min_q, inc_min_d;
  logic               show_alarm_q, show_alarm_d;
  logic [2:0]         blink_mask_q, blink_mask_d;
  snd_e               snd_sel_q, snd_sel_d;

  logic               sec_tick_c;
  logic               alarm_match_c, snooze_match_c, trigger_c, chime_c;
  logic [SUM_W-1:0]   min_sum_c;
  hm_t                snooze_tgt_c;

  assign sec_tick_c     = (second_i != second_q);
  assign alarm_match_c  = (hour_i == alarm_q.hour) && (minute_i == alarm_q.minute);
  assign snooze_match_c = snooze_pend_q && (hour_i == snooze_q.hour) &&
                          (minute_i == snooze_q.minute);
  // A simultaneous mode press wins over the trigger so ringing never starts outside RUN.
  assign trigger_c      = (mode_q == RUN) && alarm_en_i && !ringing_q && !mode_p &&
                          sec_tick_c && (second_i == '0) && (alarm_match_c || snooze_match_c);
  assign chime_c        = (mode_q == RUN) && !ringing_q && (minute_i == '0) &&
                          (second_i < TIME_W'(CHIME_SECONDS));

  // Snooze target: current time plus offset, minute overflow carried into the hour.
  assign min_sum_c = {1'b0, minute_i} + SUM_W'(SNOOZE_MIN);
  always_comb begin
    snooze_tgt_c.hour   = hour_i;
    snooze_tgt_c.minute = TIME_W'(min_sum_c);
    if (min_sum_c > SUM_W'(MAX_MIN)) begin
      snooze_tgt_c.minute = TIME_W'(min_sum_c - SUM_W'(MAX_MIN + 1));
      snooze_tgt_c.hour   = wrap_inc(hour_i, TIME_W'(MAX_HOUR));
    end
  end

  // Mode FSM next state; a mode press while ringing only stops the alarm.
  always_comb begin
    mode_d = mode_q;
    if (mode_p && !ringing_q) begin
      mode_d = next_mode(mode_q);
    end
  end

  // Alarm, snooze, ring and adjust handling.
  always_comb begin
    alarm_d       = alarm_q;
    snooze_d      = snooze_q;
    snooze_pend_d = snooze_pend_q;
    ringing_d     = ringing_q;
    ring_cnt_d    = ring_cnt_q;
    inc_hour_d    = 1'b0;
    inc_min_d     = 1'b0;

    if (ringing_q) begin
      if (stop_p || mode_p || !alarm_en_i) begin
        ringing_d     = 1'b0;
        snooze_pend_d = 1'b0;
      end else if (adj_p && (mode_q == RUN)) begin
        ringing_d     = 1'b0;
        snooze_pend_d = 1'b1;
        snooze_d      = snooze_tgt_c;
      end else if (sec_tick_c) begin
        ring_cnt_d = ring_cnt_q + RING_W'(1);
        if (ring_cnt_d == RING_W'(RING_SECONDS)) begin
          ringing_d = 1'b0;
        end
      end
    end else if (trigger_c) begin
      ringing_d  = 1'b1;
      ring_cnt_d = '0;
      if (snooze_match_c) begin
        snooze_pend_d = 1'b0;
      end
    end

    if (adj_p) begin
      case (mode_q)
        SET_H:   inc_hour_d = 1'b1;
        SET_M:   inc_min_d  = 1'b1;
        SET_AH:  alarm_d.hour   = wrap_inc(alarm_q.hour, TIME_W'(MAX_HOUR));
        SET_AM:  alarm_d.minute = wrap_inc(alarm_q.minute, TIME_W'(MAX_MIN));
        default: ;
      endcase
    end
  end

  // Blink phase, display controls and speaker selection.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_ph_d  = blink_ph_q;
    if (mode_d != mode_q) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end

    show_alarm_d = (mode_d == SET_AH) || (mode_d == SET_AM);
    case (mode_d)
      SET_H, SET_AH: blink_mask_d = {blink_ph_d, 2'b00};
      SET_M, SET_AM: blink_mask_d = {1'b0, blink_ph_d, 1'b0};
      default:       blink_mask_d = 3'b000;
    endcase

    if (ringing_q) begin
      snd_sel_d = SND_ALARM;
    end else if (chime_c) begin
      snd_sel_d = SND_CHIME;
    end else begin
      snd_sel_d = SND_NONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q         <= RUN;
      alarm_q.hour   <= TIME_W'(ALARM_RST_H);
      alarm_q.minute <= TIME_W'(ALARM_RST_M);
      snooze_q       <= '0;
      snooze_pend_q  <= 1'b0;
      ringing_q      <= 1'b0;
      ring_cnt_q     <= '0;
      blink_cnt_q    <= '0;
      blink_ph_q     <= 1'b0;
      second_q       <= '0;
      inc_hour_q     <= 1'b0;
      inc_min_q      <= 1'b0;
      show_alarm_q   <= 1'b0;
      blink_mask_q   <= 3'b000;
      snd_sel_q      <= SND_NONE;
    end else begin
      mode_q         <= mode_d;
      alarm_q        <= alarm_d;
      snooze_q       <= snooze_d;
      snooze_pend_q  <= snooze_pend_d;
      ringing_q      <= ringing_d;
      ring_cnt_q     <= ring_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_ph_q     <= blink_ph_d;
      second_q       <= second_i;
      inc_hour_q     <= inc_hour_d;
      inc_min_q      <= inc_min_d;
      show_alarm_q   <= show_alarm_d;
      blink_mask_q   <= blink_mask_d;
      snd_sel_q      <= snd_sel_d;
    end
  end

  assign inc_hour_o     = inc_hour_q;
  assign inc_min_o      = inc_min_q;
  assign mode_o         = mode_q;
  assign show_alarm_o   = show_alarm_q;
  assign blink_mask_o   = blink_mask_q;
  assign alarm_hour_o   = alarm_q.hour;
  assign alarm_minute_o = alarm_q.minute;
  assign ringing_o      = ringing_q;
  assign snd_sel_o      = snd_sel_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: vector table in RUN plus hand sequences for
// mode stepping, blinking, time/alarm setting, snooze, ring timeout and chime.
module tb_clock_mode_ctrl;

  localparam int BTN_NONE = 0;
  localparam int BTN_STOP = 1;
  localparam int BTN_ADJ  = 2;
  localparam int BTN_MODE = 3;

  logic       clk, rst_n;
  logic       btn_mode, btn_adj, btn_stop, alarm_en;
  logic [5:0] hour, minute, second;
  logic       inc_hour, inc_min;
  logic [2:0] mode;
  logic       show_alarm;
  logic [2:0] blink_mask;
  logic [5:0] alarm_hour, alarm_minute;
  logic       ringing;
  logic [1:0] snd_sel;

  int n_checks = 0;
  int n_fail   = 0;

  clock_mode_ctrl #(
    .DEB_CYCLES(4), .BLINK_CYCLES(8), .RING_SECONDS(60), .SNOOZE_MIN(5),
    .CHIME_SECONDS(2), .ALARM_RST_H(7), .ALARM_RST_M(0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .btn_mode_i(btn_mode), .btn_adj_i(btn_adj), .btn_stop_i(btn_stop),
    .alarm_en_i(alarm_en),
    .hour_i(hour), .minute_i(minute), .second_i(second),
    .inc_hour_o(inc_hour), .inc_min_o(inc_min),
    .mode_o(mode), .show_alarm_o(show_alarm), .blink_mask_o(blink_mask),
    .alarm_hour_o(alarm_hour), .alarm_minute_o(alarm_minute),
    .ringing_o(ringing), .snd_sel_o(snd_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] h, m, s;
    logic       en;
    int         btn;
    logic       exp_ring;
    logic [1:0] exp_snd;
  } vec_t;

  vec_t vecs[17];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input int which);
    case (which)
      BTN_STOP: btn_stop = 1'b1;
      BTN_ADJ:  btn_adj  = 1'b1;
      BTN_MODE: btn_mode = 1'b1;
      default:  ;
    endcase
    step(10);
    btn_stop = 1'b0;
    btn_adj  = 1'b0;
    btn_mode = 1'b0;
    step(10);
  endtask

  task automatic press_n(input int which, input int n);
    for (int i = 0; i < n; i++) press(which);
  endtask

  task automatic set_time(input int h, input int m, input int s, input int wait_cyc);
    hour   = 6'(h);
    minute = 6'(m);
    second = 6'(s);
    step(wait_cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt_h, cnt_m;
    bit found;

    // alarm 07:00 from reset, mode RUN throughout the table
    vecs[0]  = '{6'd6,  6'd59, 6'd59, 1'b1, BTN_NONE, 1'b0, 2'd0};
    vecs[1]  = '{6'd7,  6'd0,  6'd0,  1'b1, BTN_NONE, 1'b1, 2'd2};
    vecs[2]  = '{6'd7,  6'd0,  6'd0,  1'b1, BTN_STOP, 1'b0, 2'd1};
    vecs[3]  = '{6'd7,  6'd0,  6'd0,  1'b1, BTN_NONE, 1'b0, 2'd1};
    vecs[4]  = '{6'd7,  6'd0,  6'd1,  1'b1, BTN_NONE, 1'b0, 2'd1};
    vecs[5]  = '{6'd7,  6'd0,  6'd2,  1'b1, BTN_NONE, 1'b0, 2'd0};
    vecs[6]  = '{6'd7,  6'd0,  6'd3,  1'b1, BTN_ADJ,  1'b0, 2'd0};
    vecs[7]  = '{6'd6,  6'd59, 6'd59, 1'b0, BTN_NONE, 1'b0, 2'd0};
    vecs[8]  = '{6'd7,  6'd0,  6'd0,  1'b0, BTN_NONE, 1'b0, 2'd1};
    vecs[9]  = '{6'd6,  6'd59, 6'd59, 1'b1, BTN_NONE, 1'b0, 2'd0};
    vecs[10] = '{6'd7,  6'd0,  6'd0,  1'b1, BTN_NONE, 1'b1, 2'd2};
    vecs[11] = '{6'd7,  6'd0,  6'd0,  1'b0, BTN_NONE, 1'b0, 2'd1};
    vecs[12] = '{6'd7,  6'd0,  6'd5,  1'b1, BTN_NONE, 1'b0, 2'd0};
    vecs[13] = '{6'd6,  6'd59, 6'd59, 1'b1, BTN_NONE, 1'b0, 2'd0};
    vecs[14] = '{6'd7,  6'd0,  6'd0,  1'b1, BTN_NONE, 1'b1, 2'd2};
    vecs[15] = '{6'd7,  6'd0,  6'd0,  1'b1, BTN_MODE, 1'b0, 2'd1};
    vecs[16] = '{6'd7,  6'd0,  6'd2,  1'b1, BTN_NONE, 1'b0, 2'd0};

    rst_n = 1'b0;
    btn_mode = 1'b0; btn_adj = 1'b0; btn_stop = 1'b0;
    alarm_en = 1'b1;
    hour = 6'd6; minute = 6'd59; second = 6'd59;
    step(3);
    chk("reset mode", int'(mode), 0);
    chk("reset show_alarm", int'(show_alarm), 0);
    chk("reset blink_mask", int'(blink_mask), 0);
    chk("reset alarm_hour", int'(alarm_hour), 7);
    chk("reset alarm_minute", int'(alarm_minute), 0);
    chk("reset ringing", int'(ringing), 0);
    chk("reset snd_sel", int'(snd_sel), 0);
    chk("reset inc pulses", int'({inc_hour, inc_min}), 0);
    rst_n = 1'b1;
    step(3);

    for (int i = 0; i < 17; i++) begin
      hour = vecs[i].h; minute = vecs[i].m; second = vecs[i].s;
      alarm_en = vecs[i].en;
      step(3);
      if (vecs[i].btn != BTN_NONE) press(vecs[i].btn);
      step(2);
      chk($sformatf("vec%0d ringing", i), int'(ringing), int'(vecs[i].exp_ring));
      chk($sformatf("vec%0d snd_sel", i), int'(snd_sel), int'(vecs[i].exp_snd));
      chk($sformatf("vec%0d mode", i), int'(mode), 0);
    end

    // Hold mode until SET_H appears, then watch the blink phase.
    btn_mode = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step(1);
      if (mode == 3'd1) found = 1'b1;
    end
    chk("enter SET_H", int'(found), 1);
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("blink bit2 k=%0d", k), int'(blink_mask[2]), (k / 8) % 2);
      chk($sformatf("blink bit1 k=%0d", k), int'(blink_mask[1]), 0);
      step(1);
    end
    btn_mode = 1'b0;
    step(10);
    chk("held mode no repeat", int'(mode), 1);
    chk("SET_H show_alarm", int'(show_alarm), 0);

    press(BTN_MODE);
    chk("mode 2", int'(mode), 2);
    chk("mode 2 show_alarm", int'(show_alarm), 0);
    press(BTN_MODE);
    chk("mode 3", int'(mode), 3);
    chk("mode 3 show_alarm", int'(show_alarm), 1);
    press(BTN_MODE);
    chk("mode 4", int'(mode), 4);
    chk("mode 4 show_alarm", int'(show_alarm), 1);
    press(BTN_MODE);
    chk("mode 0", int'(mode), 0);
    chk("mode 0 show_alarm", int'(show_alarm), 0);
    chk("mode 0 blink_mask", int'(blink_mask), 0);

    // SET_H: long hold gives one single-cycle inc_hour; a short glitch gives none.
    press(BTN_MODE);
    chk("SET_H again", int'(mode), 1);
    cnt_h = 0; cnt_m = 0;
    btn_adj = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      cnt_h += int'(inc_hour);
      cnt_m += int'(inc_min);
    end
    btn_adj = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      cnt_h += int'(inc_hour);
      cnt_m += int'(inc_min);
    end
    chk("held adj inc_hour cycles", cnt_h, 1);
    chk("held adj inc_min cycles", cnt_m, 0);
    cnt_h = 0;
    btn_adj = 1'b1;
    step(2);
    btn_adj = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      cnt_h += int'(inc_hour);
    end
    chk("glitch adj inc_hour cycles", cnt_h, 0);

    // Alarm hour/minute wrap, then leave the alarm at 23:58.
    press_n(BTN_MODE, 2);
    chk("SET_AH", int'(mode), 3);
    press_n(BTN_ADJ, 16);
    chk("alarm_hour 23", int'(alarm_hour), 23);
    press(BTN_ADJ);
    chk("alarm_hour wrap", int'(alarm_hour), 0);
    chk("alarm_minute untouched", int'(alarm_minute), 0);
    press_n(BTN_ADJ, 23);
    press(BTN_MODE);
    chk("SET_AM", int'(mode), 4);
    press_n(BTN_ADJ, 59);
    chk("alarm_minute 59", int'(alarm_minute), 59);
    press(BTN_ADJ);
    chk("alarm_minute wrap", int'(alarm_minute), 0);
    chk("alarm_hour after min wrap", int'(alarm_hour), 23);
    press_n(BTN_ADJ, 58);
    press(BTN_MODE);
    chk("back to RUN", int'(mode), 0);
    chk("alarm 23:58 min", int'(alarm_minute), 58);

    // Snooze across midnight: 23:58 + 5 min = 00:03.
    set_time(23, 57, 59, 3);
    set_time(23, 58, 0, 4);
    chk("2358 ringing", int'(ringing), 1);
    chk("2358 snd_sel", int'(snd_sel), 2);
    press(BTN_ADJ);
    chk("snooze ringing", int'(ringing), 0);
    chk("snooze snd_sel", int'(snd_sel), 0);
    set_time(0, 2, 59, 3);
    chk("0002:59 ringing", int'(ringing), 0);
    set_time(0, 3, 0, 4);
    chk("snooze ring 00:03", int'(ringing), 1);
    chk("snooze ring snd_sel", int'(snd_sel), 2);
    press(BTN_STOP);
    chk("snooze stop", int'(ringing), 0);
    set_time(0, 2, 59, 3);
    set_time(0, 3, 0, 4);
    chk("snooze not pending", int'(ringing), 0);

    // Untouched ring ends after RING_SECONDS second ticks.
    set_time(23, 57, 59, 3);
    set_time(23, 58, 0, 4);
    chk("timeout ring start", int'(ringing), 1);
    for (int s = 1; s < 60; s++) set_time(23, 58, s, 2);
    chk("ringing after 59 ticks", int'(ringing), 1);
    set_time(23, 59, 0, 3);
    chk("ringing after 60 ticks", int'(ringing), 0);
    chk("timeout snd_sel", int'(snd_sel), 0);

    // Hourly chime.
    set_time(12, 59, 59, 3);
    chk("chime 12:59:59", int'(snd_sel), 0);
    set_time(13, 0, 0, 3);
    chk("chime 13:00:00", int'(snd_sel), 1);
    set_time(13, 0, 1, 3);
    chk("chime 13:00:01", int'(snd_sel), 1);
    set_time(13, 0, 2, 3);
    chk("chime 13:00:02", int'(snd_sel), 0);

    // Alarm at 13:00 overrides the chime.
    press_n(BTN_MODE, 3);
    chk("SET_AH for 13:00", int'(mode), 3);
    press_n(BTN_ADJ, 14);
    chk("alarm_hour 13", int'(alarm_hour), 13);
    press(BTN_MODE);
    press_n(BTN_ADJ, 2);
    chk("alarm_minute 0", int'(alarm_minute), 0);
    press(BTN_MODE);
    chk("RUN for 13:00", int'(mode), 0);
    set_time(12, 59, 59, 3);
    set_time(13, 0, 0, 4);
    chk("13:00 alarm ringing", int'(ringing), 1);
    chk("13:00 alarm snd_sel", int'(snd_sel), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
